// File: rtl/mc_pkg.sv
// Shared definitions for the microcode sequencer: sequencing encodings, microword
// field layout, control-bit positions and FSM states.
package mc_pkg;

  typedef enum logic [1:0] {
    SeqNext     = 2'b00,
    SeqDispatch = 2'b01,
    SeqJump     = 2'b10,
    SeqFetch    = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StWaitOp
  } state_e;

  // Microword layout is {ctrl, seq, next}; next starts at bit 0, seq sits just above it.
  localparam int unsigned SEQ_W    = 2;
  localparam int unsigned NEXT_LSB = 0;

  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_REGDST   = 4;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_BRANCH   = 0;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Load, opcode-handshake and control-output signals of the microcode sequencer.
interface microcode_sequencer_if #(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned AW     = 10,
  parameter int unsigned OP_W   = 4
);
  localparam int unsigned MW = CTRL_W + 2 + AW;

  logic              run;
  logic              load_we;
  logic              load_sel;
  logic [AW-1:0]     load_addr;
  logic [MW-1:0]     load_data;
  logic              op_valid;
  logic [OP_W-1:0]   opcode;
  logic              op_ready;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_valid;
  logic [AW-1:0]     upc;

  modport master (
    output run, load_we, load_sel, load_addr, load_data, op_valid, opcode,
    input  op_ready, ctrl, ctrl_valid, upc
  );

  modport slave (
    input  run, load_we, load_sel, load_addr, load_data, op_valid, opcode,
    output op_ready, ctrl, ctrl_valid, upc
  );
endinterface

// File: rtl/mc_store.sv
// Control store: simple dual-port RAM, one write port and one synchronous read-first
// read port. Contents are never reset.
module mc_store #(
  parameter int unsigned DW = 19,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // Read samples the array before the write lands: same-address write is seen next read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps a micro-PC through the control store, presenting each
// microword's control field, with opcode dispatch through a loadable table.
module microcode_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned AW     = 10,
  parameter int unsigned OP_W   = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  microcode_sequencer_if.slave  bus
);
  localparam int unsigned MW = CTRL_W + 2 + AW;
  localparam int unsigned ND = 2 ** OP_W;

  state_e            state_q, state_d;
  logic [AW-1:0]     upc_q, upc_d;
  logic [MW-1:0]     word;
  seq_e              seq;
  logic [AW-1:0]     word_next;
  logic [CTRL_W-1:0] word_ctrl;
  logic              op_ready;
  logic              store_we;
  logic [AW-1:0]     disp_q [ND];

  assign store_we = bus.load_we & ~bus.load_sel;

  // Read address is the next micro-PC so the word for upc_q is ready when it takes effect.
  mc_store #(
    .DW(MW),
    .AW(AW)
  ) u_store (
    .clk  (clk),
    .we   (store_we),
    .waddr(bus.load_addr),
    .wdata(bus.load_data),
    .raddr(upc_d),
    .rdata(word)
  );

  always_ff @(posedge clk) begin
    if (bus.load_we && bus.load_sel) begin
      disp_q[bus.load_addr[OP_W-1:0]] <= bus.load_data[AW-1:0];
    end
  end

  always_comb begin
    seq       = seq_e'(word[AW +: SEQ_W]);
    word_next = word[NEXT_LSB +: AW];
    word_ctrl = word[MW-1 -: CTRL_W];
    state_d   = state_q;
    upc_d     = upc_q;
    op_ready  = 1'b0;
    if (!bus.run) begin
      state_d = StIdle;
      upc_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StPrime;
          upc_d   = '0;
        end
        StPrime: state_d = StRun;
        StRun: begin
          unique case (seq)
            SeqNext:  upc_d = upc_q + AW'(1);
            SeqJump:  upc_d = word_next;
            SeqFetch: upc_d = '0;
            SeqDispatch: begin
              if (bus.op_valid) begin
                op_ready = 1'b1;
                upc_d    = disp_q[bus.opcode];
              end else begin
                state_d = StWaitOp;
              end
            end
          endcase
        end
        StWaitOp: begin
          if (bus.op_valid) begin
            op_ready = 1'b1;
            upc_d    = disp_q[bus.opcode];
            state_d  = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

  // Controls are live only in RUN, so a dispatch word fires once even while waiting.
  assign bus.ctrl       = (state_q == StRun) ? word_ctrl : '0;
  assign bus.ctrl_valid = (state_q == StRun);
  assign bus.upc        = upc_q;
  assign bus.op_ready   = op_ready;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: stimulus queues expected control words and
// dispatch handshakes; a negedge monitor pops and compares them as the DUT presents them.
module tb_microcode_sequencer;
  import mc_pkg::*;

  localparam int unsigned CTRL_W = 7;
  localparam int unsigned AW     = 10;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned MW     = CTRL_W + 2 + AW;

  localparam logic [6:0] C_RFMT = 7'((1 << CTRL_REGDST) | (1 << CTRL_REGWRITE));
  localparam logic [6:0] C_LW   = 7'((1 << CTRL_ALUSRC) | (1 << CTRL_MEMTOREG) |
                                     (1 << CTRL_REGWRITE) | (1 << CTRL_MEMREAD));
  localparam logic [6:0] C_SW   = 7'((1 << CTRL_ALUSRC) | (1 << CTRL_MEMWRITE));
  localparam logic [6:0] C_BEQ  = 7'(1 << CTRL_BRANCH);
  localparam logic [6:0] C_RD   = 7'(1 << CTRL_MEMREAD);
  localparam logic [6:0] C_WR   = 7'(1 << CTRL_REGWRITE);
  localparam logic [6:0] C_MW   = 7'(1 << CTRL_MEMWRITE);
  localparam logic [6:0] C_MR   = 7'((1 << CTRL_MEMTOREG) | (1 << CTRL_REGWRITE));

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     upc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t          exp_q[$];
  logic [AW-1:0] op_q[$];

  microcode_sequencer_if #(.CTRL_W(CTRL_W), .AW(AW), .OP_W(OP_W)) bus ();

  microcode_sequencer #(
    .CTRL_W(CTRL_W),
    .AW    (AW),
    .OP_W  (OP_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mw(input logic [6:0] c, input seq_e s,
                                       input logic [AW-1:0] n);
    return {c, s, n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic load(input logic sel, input logic [AW-1:0] addr, input logic [MW-1:0] data);
    bus.load_we   = 1'b1;
    bus.load_sel  = sel;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_we = 1'b0;
  endtask

  task automatic expect_word(input logic [6:0] c, input logic [AW-1:0] u);
    exp_t e;
    e.ctrl = c;
    e.upc  = u;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size() + op_q.size()), 32'd0);
    exp_q.delete();
    op_q.delete();
  endtask

  always @(negedge clk) begin
    if (bus.ctrl_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got ctrl=%0h upc=%0h, expected none",
                 bus.ctrl, bus.upc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.ctrl !== e.ctrl || bus.upc !== e.upc) begin
          errors++;
          $display("FAIL word: got ctrl=%0h upc=%0h, expected ctrl=%0h upc=%0h",
                   bus.ctrl, bus.upc, e.ctrl, e.upc);
        end
      end
    end
    if (bus.op_ready) begin
      checks++;
      if (op_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_op_ready: got op_ready at upc=%0h, expected none", bus.upc);
      end else begin
        logic [AW-1:0] u;
        u = op_q.pop_front();
        if (bus.upc !== u) begin
          errors++;
          $display("FAIL op_ready_upc: got %0h, expected %0h", bus.upc, u);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run       = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_sel  = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.op_valid  = 1'b0;
    bus.opcode    = '0;
    reset_n       = 1'b0;
    #3;
    check("reset_ctrl", 32'(bus.ctrl), 32'd0);
    check("reset_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
    check("reset_op_ready", 32'(bus.op_ready), 32'd0);
    check("reset_upc", 32'(bus.upc), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Straight-line program with FETCH back to 0
    load(1'b0, 10'h000, mw(C_RFMT, SeqNext, 10'h0));
    load(1'b0, 10'h001, mw(C_LW, SeqNext, 10'h0));
    load(1'b0, 10'h002, mw(C_SW, SeqNext, 10'h0));
    load(1'b0, 10'h003, mw(C_BEQ, SeqFetch, 10'h0));
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    expect_word(C_SW, 10'h002);
    expect_word(C_BEQ, 10'h003);
    expect_word(C_RFMT, 10'h000);
    bus.run = 1'b1;
    tick();
    check("prime_no_valid", 32'(bus.ctrl_valid), 32'd0);
    repeat (5) tick();
    bus.run = 1'b0;
    tick();
    check("idle_upc", 32'(bus.upc), 32'd0);
    check("idle_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
    drain("fetch_loop_drained");

    // Jump into a dispatch word, wait for an opcode, then jump to the top word and wrap
    load(1'b0, 10'h003, mw(C_BEQ, SeqJump, 10'h005));
    load(1'b0, 10'h005, mw(C_RD, SeqDispatch, 10'h0));
    load(1'b0, 10'h020, mw(C_WR, SeqJump, 10'h3FF));
    load(1'b0, 10'h3FF, mw(C_MW, SeqNext, 10'h0));
    load(1'b1, 10'h003, MW'(10'h020));
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    expect_word(C_SW, 10'h002);
    expect_word(C_BEQ, 10'h003);
    expect_word(C_RD, 10'h005);
    expect_word(C_WR, 10'h020);
    expect_word(C_MW, 10'h3FF);
    expect_word(C_RFMT, 10'h000);
    op_q.push_back(10'h005);
    bus.run = 1'b1;
    tick();
    repeat (5) tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wait_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
      check("wait_op_ready", 32'(bus.op_ready), 32'd0);
      tick();
    end
    check("wait_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
    check("wait_upc_held", 32'(bus.upc), 32'h005);
    bus.op_valid  = 1'b1;
    bus.opcode    = 4'd3;
    bus.load_we   = 1'b1;
    bus.load_sel  = 1'b1;
    bus.load_addr = 10'h003;
    bus.load_data = MW'(10'h030);
    #1;
    check("dispatch_op_ready", 32'(bus.op_ready), 32'd1);
    tick();
    bus.load_we = 1'b0;
    check("op_ready_pulse_end", 32'(bus.op_ready), 32'd0);
    check("dispatch_old_entry", 32'(bus.upc), 32'h020);
    tick();
    tick();
    bus.run      = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    drain("dispatch_drained");

    // Reset while waiting for an opcode, then restart
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    expect_word(C_SW, 10'h002);
    expect_word(C_BEQ, 10'h003);
    expect_word(C_RD, 10'h005);
    bus.run = 1'b1;
    tick();
    repeat (5) tick();
    tick();
    tick();
    reset_n       = 1'b0;
    bus.op_valid  = 1'b1;
    bus.opcode    = 4'd3;
    #1;
    check("rst_wait_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_wait_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
    check("rst_wait_op_ready", 32'(bus.op_ready), 32'd0);
    check("rst_wait_upc", 32'(bus.upc), 32'd0);
    tick();
    tick();
    bus.op_valid = 1'b0;
    reset_n      = 1'b1;
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    tick();
    check("restart_prime", 32'(bus.ctrl_valid), 32'd0);
    tick();
    check("restart_upc", 32'(bus.upc), 32'd0);
    tick();
    bus.run = 1'b0;
    tick();
    drain("restart_drained");

    // Overwrite word 2 on the same edge it is read: old word now, new word next time round
    load(1'b0, 10'h003, mw(C_BEQ, SeqFetch, 10'h0));
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    expect_word(C_SW, 10'h002);
    expect_word(C_BEQ, 10'h003);
    expect_word(C_RFMT, 10'h000);
    expect_word(C_LW, 10'h001);
    expect_word(C_MR, 10'h002);
    expect_word(C_BEQ, 10'h003);
    bus.run = 1'b1;
    tick();
    tick();
    tick();
    load(1'b0, 10'h002, mw(C_MR, SeqNext, 10'h0));
    check("rf_upc_at_2", 32'(bus.upc), 32'h002);
    repeat (5) tick();
    bus.run = 1'b0;
    tick();
    drain("read_first_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 7: control-field width (ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch at bits 6..0).
REQ-002 The block SHALL have parameter AW, default 10: control-store address width, DEPTH = 2**AW.
REQ-003 The block SHALL have parameter OP_W, default 4: opcode width, dispatch table depth = 2**OP_W.
REQ-004 The block SHALL define microword width MW = CTRL_W+2+AW, with fields {ctrl[CTRL_W-1:0], seq[1:0], next[AW-1:0]}, ctrl at the MSBs.
REQ-005 The block SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have ports: run  in  1  sequencer enable.
REQ-008 The block SHALL have ports: load_we  in  1  write strobe; load_sel  in  1  0=control store, 1=dispatch table.
REQ-009 The block SHALL have ports: load_addr  in  AW  write address (low OP_W bits for dispatch); load_data  in  MW  write data (low AW bits for dispatch).
REQ-010 The block SHALL have ports: op_valid  in  1, opcode  in  OP_W  decoded-instruction handshake; op_ready  out  1.
REQ-011 The block SHALL have ports: ctrl  out  CTRL_W  current control word; ctrl_valid  out  1; upc  out  AW  current micro-PC.

Function
REQ-012 The block SHALL implement FSM states IDLE, PRIME, RUN, WAIT_OP.
REQ-013 In IDLE, the block SHALL hold upc=0, ctrl=0, ctrl_valid=0, op_ready=0; run=1 -> PRIME.
REQ-014 In PRIME, the block SHALL read store[0] synchronously and go to RUN; the first valid ctrl SHALL appear exactly 2 edges after run is sampled high.
REQ-015 In RUN, ctrl SHALL equal the ctrl field of store[upc], with ctrl_valid=1.
REQ-016 seq=00 (NEXT) SHALL set upc <= upc+1, wrapping from DEPTH-1 to 0.
REQ-017 seq=10 (JUMP) SHALL set upc <= next; seq=11 (FETCH) SHALL set upc <= 0.
REQ-018 seq=01 (DISPATCH) with op_valid=1 SHALL drive op_ready=1 combinationally in that cycle and set upc <= dispatch[opcode]; the block SHALL stay in RUN.
REQ-019 seq=01 with op_valid=0 SHALL go to WAIT_OP with upc held. In WAIT_OP, ctrl=0 and ctrl_valid=0, so the dispatch word's controls fire once only; op_valid=1 -> op_ready=1, upc <= dispatch[opcode], and the block SHALL move to RUN.
REQ-020 op_ready SHALL be 0 in every state/word except those given in REQ-018 and REQ-019; op_valid SHALL be ignored otherwise.
REQ-021 run=0, sampled in any state, SHALL force IDLE at the next edge with upc=0; in-flight dispatch SHALL be abandoned without op_ready.
REQ-022 Store reads SHALL be synchronous, addressed by next-upc, and read-first: a write to the address being read in the same cycle SHALL be visible only from the following read.
REQ-023 Writes SHALL be accepted in every state; a dispatch-table write in the same cycle as a dispatch SHALL give the old entry.
REQ-024 Store and dispatch contents SHALL be undefined until written and SHALL NOT be cleared by reset.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, upc=0, ctrl=0, ctrl_valid=0, op_ready=0, including mid-dispatch; operation SHALL resume per REQ-013 after release.

Structure
REQ-026 seq encodings, field-offset localparams and the ctrl bit indices SHALL live in a shared package, mc_pkg.
REQ-027 The control store SHALL be one sub-module, mc_store (simple dual-port, one write and one synchronous read-first read, block-RAM inferable); the dispatch table SHALL be a register array in the top level.

Verification
REQ-028 Load store[0..3] = R-fmt ctrl 7'b0011000 NEXT, lw 7'b1101100 NEXT, sw 7'b1000010 NEXT, beq 7'b0000001 FETCH; run=1 -> ctrl sequence 0x18,0x6C,0x42,0x01,0x18 on consecutive cycles starting 2 edges after run.
REQ-029 store[5] = DISPATCH, dispatch[3]=0x20, op_valid=0 for 4 cycles then opcode=3 -> ctrl_valid low 4 cycles, op_ready single-cycle pulse, upc=0x20 next cycle.
REQ-030 store[0x3FF] = NEXT -> upc wraps to 0x000.
REQ-031 Assert reset_n low in WAIT_OP -> all outputs 0 immediately, no op_ready; after release with run=1, restart from upc=0.
REQ-032 Write store[2] in the same cycle upc advances to 2 -> old word executes; re-entry to 2 executes the new word.
